// File: rtl/la_clkdiv_pkg.sv
// la_clkdiv_pkg
//   Shared definitions for the programmable integer clock divider.
//   - la_clkdiv_state_e : divider FSM state encoding
//   - LA_CLKDIV_MIN_RATIO : smallest divide ratio ever used; requests of
//     0 or 1 are promoted to this value
package la_clkdiv_pkg;

  typedef enum logic {
    LA_CLKDIV_IDLE = 1'b0,
    LA_CLKDIV_RUN  = 1'b1
  } la_clkdiv_state_e;

  localparam int unsigned LA_CLKDIV_MIN_RATIO = 2;

endpackage : la_clkdiv_pkg

// File: rtl/la_clkdiv.sv
// la_clkdiv
//   Programmable integer clock divider producing a registered, glitch-free
//   divided clock. Start, stop and ratio changes are only honoured at period
//   boundaries, so clkout never carries a runt pulse (except on reset).
//
//   Ports
//     clk     : reference clock, all state changes on its rising edge
//     reset   : synchronous, active-high reset
//     en      : run request, sampled at period boundaries (and in IDLE)
//     div     : requested divide ratio; 0 and 1 are treated as 2
//     clkout  : divided clock, straight from a flop
//     rise    : one-cycle pulse aligned with the first high cycle of clkout
//     active  : high while the divider is running
//     div_ack : one-cycle pulse when a different ratio is loaded
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | stopped, clkout low, cnt held at 0, waiting for en
//   RUN   | dividing; cnt walks 0..R-1, clkout high for cnt < ceil(R/2)
module la_clkdiv
  import la_clkdiv_pkg::*;
#(
  parameter int unsigned DIVW = 8,
  parameter string       PROP = "DEFAULT"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  output logic            clkout,
  output logic            rise,
  output logic            active,
  output logic            div_ack
);

  localparam logic [DIVW-1:0] ONE   = DIVW'(1);
  localparam logic [DIVW-1:0] MIN_R = DIVW'(LA_CLKDIV_MIN_RATIO);

  la_clkdiv_state_e state_q, state_d;

  logic [DIVW-1:0] ratio_q, ratio_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            clkout_q, clkout_d;
  logic            rise_q, rise_d;
  logic            active_q, active_d;
  logic            div_ack_q, div_ack_d;

  logic [DIVW-1:0] div_clamped;
  logic [DIVW:0]   high_cnt;
  logic [DIVW:0]   cnt_inc;
  logic            at_boundary;
  logic            start_period;

  // ratio_q only ever holds clamped values, so it is already max(ratio, 2).
  assign div_clamped = (div < MIN_R) ? MIN_R : div;

  // One extra bit so (R+1) cannot overflow at the largest ratio.
  assign high_cnt    = ({1'b0, ratio_q} + {{DIVW{1'b0}}, 1'b1}) >> 1;
  assign cnt_inc     = {1'b0, cnt_q} + {{DIVW{1'b0}}, 1'b1};
  assign at_boundary = (cnt_q == (ratio_q - ONE));

  // State register plus the registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LA_CLKDIV_IDLE;
      ratio_q   <= MIN_R;
      cnt_q     <= '0;
      clkout_q  <= 1'b0;
      rise_q    <= 1'b0;
      active_q  <= 1'b0;
      div_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ratio_q   <= ratio_d;
      cnt_q     <= cnt_d;
      clkout_q  <= clkout_d;
      rise_q    <= rise_d;
      active_q  <= active_d;
      div_ack_q <= div_ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LA_CLKDIV_IDLE: begin
        if (en) state_d = LA_CLKDIV_RUN;
      end
      LA_CLKDIV_RUN: begin
        // en is only looked at on the last cycle of a period.
        if (at_boundary && !en) state_d = LA_CLKDIV_IDLE;
      end
      default: state_d = LA_CLKDIV_IDLE;
    endcase
  end

  // Next values of the counter, ratio register and registered outputs.
  always_comb begin
    ratio_d      = ratio_q;
    cnt_d        = cnt_q;
    clkout_d     = clkout_q;
    rise_d       = 1'b0;
    div_ack_d    = 1'b0;
    start_period = 1'b0;

    case (state_q)
      LA_CLKDIV_IDLE: begin
        cnt_d    = '0;
        clkout_d = 1'b0;
        if (en) start_period = 1'b1;
      end
      LA_CLKDIV_RUN: begin
        if (!at_boundary) begin
          cnt_d    = cnt_q + ONE;
          clkout_d = (cnt_inc < high_cnt);
        end else if (!en) begin
          // clkout is already low here because R-1 >= ceil(R/2).
          cnt_d    = '0;
          clkout_d = 1'b0;
        end else begin
          start_period = 1'b1;
        end
      end
      default: begin
        cnt_d    = '0;
        clkout_d = 1'b0;
      end
    endcase

    // A new period always begins with a high cycle and a freshly sampled div.
    if (start_period) begin
      ratio_d   = div_clamped;
      div_ack_d = (div_clamped != ratio_q);
      cnt_d     = '0;
      clkout_d  = 1'b1;
      rise_d    = 1'b1;
    end
  end

  assign active_d = (state_d == LA_CLKDIV_RUN);

  assign clkout  = clkout_q;
  assign rise    = rise_q;
  assign active  = active_q;
  assign div_ack = div_ack_q;

endmodule : la_clkdiv

// File: tb/tb_la_clkdiv.sv
// tb_la_clkdiv
//   Directed bench for la_clkdiv. A period-level reference model (a queue
//   holding the clkout values still owed in the current period) is compared
//   against the DUT after every clock edge; literal waveform expectations
//   pin the model for the interesting cases.
module tb_la_clkdiv;

  localparam int DIVW = 8;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            en    = 1'b0;
  logic [DIVW-1:0] div   = '0;
  logic            clkout, rise, active, div_ack;

  int n_checks = 0;
  int n_err    = 0;

  la_clkdiv #(.DIVW(DIVW), .PROP("DEFAULT")) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .div    (div),
    .clkout (clkout),
    .rise   (rise),
    .active (active),
    .div_ack(div_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: when a period starts, its whole clkout sequence
  // (ceil(R/2) ones then zeros) is queued; a new period or a stop is only
  // decided once the queue is empty.
  int m_q[$];
  bit m_run    = 1'b0;
  int m_ratio  = 2;
  int m_clkout = 0;
  int m_rise   = 0;
  int m_active = 0;
  int m_ack    = 0;

  always @(posedge clk) begin
    int r;
    m_rise = 0;
    m_ack  = 0;
    if (reset) begin
      m_q.delete();
      m_run    = 1'b0;
      m_ratio  = 2;
      m_clkout = 0;
    end else if (m_run && m_q.size() != 0) begin
      m_clkout = m_q.pop_front();
    end else if (en) begin
      r       = (int'(div) < 2) ? 2 : int'(div);
      m_ack   = (r != m_ratio) ? 1 : 0;
      m_ratio = r;
      for (int i = 0; i < r; i++) m_q.push_back((i < (r + 1) / 2) ? 1 : 0);
      m_clkout = m_q.pop_front();
      m_rise   = 1;
      m_run    = 1'b1;
    end else begin
      m_run    = 1'b0;
      m_clkout = 0;
    end
    m_active = m_run ? 1 : 0;
    #1;
    check("model_clkout",  int'(clkout),  m_clkout);
    check("model_rise",    int'(rise),    m_rise);
    check("model_active",  int'(active),  m_active);
    check("model_div_ack", int'(div_ack), m_ack);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compares clkout at this and the following n-1 negedges against pat,
  // most significant bit first.
  task automatic chk_pattern(input string name, input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      check(name, int'(clkout), int'(pat[n-1-i]));
      @(negedge clk);
    end
  endtask

  // Advances at least one cycle, then stops on the next rise pulse.
  task automatic wait_rise(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (rise !== 1'b1 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check({name, "_rise_seen"}, int'(rise), 1);
  endtask

  initial begin
    int hi, lo;

    // Reset held with a run request pending: everything stays low.
    reset = 1'b1; en = 1'b1; div = 8'd4;
    cyc(3);
    check("rst_clkout",  int'(clkout),  0);
    check("rst_rise",    int'(rise),    0);
    check("rst_active",  int'(active),  0);
    check("rst_div_ack", int'(div_ack), 0);

    // Release: first edge starts a high phase, ratio 2 -> 4 is acknowledged.
    reset = 1'b0;
    cyc(1);
    check("start_clkout",  int'(clkout),  1);
    check("start_rise",    int'(rise),    1);
    check("start_active",  int'(active),  1);
    check("start_div_ack", int'(div_ack), 1);
    chk_pattern("r4_pattern", 16'b1100_1100, 8);

    // R=3
    div = 8'd3;
    wait_rise("r3");
    check("r3_ack", int'(div_ack), 1);
    chk_pattern("r3_pattern", 16'b110_110, 6);

    // div=0 and div=1 both behave as R=2; 1 after 0 is not a new ratio.
    div = 8'd0;
    wait_rise("r0");
    chk_pattern("r0_pattern", 16'b1010, 4);
    div = 8'd1;
    wait_rise("r1");
    check("r1_no_ack", int'(div_ack), 0);
    chk_pattern("r1_pattern", 16'b1010, 4);

    // Ratio change at cnt=1: the R=4 period finishes, then R=6 begins.
    div = 8'd4;
    wait_rise("chg");
    cyc(1);
    div = 8'd6;
    chk_pattern("chg_pattern", 16'b100_111000, 9);

    // Stop at cnt=1 of an R=5 period: period completes, then stays low.
    div = 8'd5;
    wait_rise("stop");
    cyc(1);
    en = 1'b0;
    chk_pattern("stop_pattern", 16'b1100_000, 7);
    check("stop_active", int'(active), 0);

    // Restart has one edge of latency; a one-cycle en dip mid-period is ignored.
    div = 8'd4;
    en  = 1'b1;
    cyc(1);
    check("restart_clkout", int'(clkout), 1);
    cyc(1);
    en = 1'b0;
    cyc(1);
    en = 1'b1;
    chk_pattern("glitch_pattern", 16'b00_1100, 6);
    check("glitch_active", int'(active), 1);

    // Largest ratio: 128 high, 127 low, then the period repeats.
    div = 8'd255;
    wait_rise("max");
    hi = 0;
    while (clkout === 1'b1 && hi < 300) begin hi++; @(negedge clk); end
    lo = 0;
    while (clkout === 1'b0 && lo < 300) begin lo++; @(negedge clk); end
    check("max_high", hi, 128);
    check("max_low",  lo, 127);
    check("max_repeat_rise", int'(rise), 1);
    hi = 0;
    while (clkout === 1'b1 && hi < 300) begin hi++; @(negedge clk); end
    check("max_high2", hi, 128);

    // Reset mid-period forces clkout low on the next edge.
    wait_rise("mid_rst");
    cyc(10);
    check("pre_rst_clkout", int'(clkout), 1);
    reset = 1'b1;
    en    = 1'b0;
    cyc(1);
    check("mid_rst_clkout", int'(clkout), 0);
    check("mid_rst_active", int'(active), 0);
    reset = 1'b0;
    cyc(3);
    check("idle_clkout", int'(clkout), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_la_clkdiv
